// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;

  // Bits needed to hold a count from 0 up to and including depth.
  function automatic int clog2p1(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Upstream/downstream bus of the pipeline register chain.
// The master side feeds payloads and controls; the slave side is the chain.
interface pipe_reg_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 1
);

  localparam int CW = clog2p1(DEPTH);

  logic [WIDTH-1:0] D;
  logic             d_valid;
  logic             e;
  logic             flush;
  logic             in_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CW-1:0]    count;

  modport master (
    output D, d_valid, e, flush,
    input  in_ready, q, q_valid, count
  );

  modport slave (
    input  D, d_valid, e, flush,
    output in_ready, q, q_valid, count
  );

endinterface

// File: rtl/pipe_stage.sv
// One {valid, payload} pipeline register. An invalid stage always holds
// RESET_VAL so bubbles never carry stale data downstream.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int                WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Flush beats load; a load of an invalid entry stores RESET_VAL.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= valid_i ? data_i : RESET_VAL;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain with global stall, synchronous flush
// and optional bubble squeezing while the output is stalled.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
  parameter bit               COLLAPSE  = 1'b0
) (
  input  logic             Clk,
  input  logic             Clrn,
  pipe_reg_chain_if.slave  bus
);

  localparam int CW = clog2p1(DEPTH);

  logic [DEPTH-1:0] valid_w;
  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH-1:0] src_valid_w;
  logic [WIDTH-1:0] src_data_w [DEPTH];
  logic [DEPTH-1:0] free_c;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // A stage may load when the output advances, or (in collapse mode) when
  // it or any stage below it has an empty slot to shift into.
  always_comb begin
    free_c = '0;
    free_c[DEPTH-1] = bus.e | (COLLAPSE & ~valid_w[DEPTH-1]);
    for (int i = DEPTH - 2; i >= 0; i--) begin
      free_c[i] = COLLAPSE ? (free_c[i+1] | ~valid_w[i]) : bus.e;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_valid_w[gi] = bus.d_valid;
        assign src_data_w[gi]  = bus.D;
      end else begin : g_body
        assign src_valid_w[gi] = valid_w[gi-1];
        assign src_data_w[gi]  = data_w[gi-1];
      end

      pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .Clk     (Clk),
        .Clrn    (Clrn),
        .load_i  (free_c[gi]),
        .flush_i (bus.flush),
        .valid_i (src_valid_w[gi]),
        .data_i  (src_data_w[gi]),
        .valid_o (valid_w[gi]),
        .data_o  (data_w[gi])
      );
    end
  endgenerate

  // Occupancy after this edge: popcount of the valid bits the stages will load.
  always_comb begin
    logic nv;
    nv      = 1'b0;
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush)      nv = 1'b0;
      else if (free_c[i]) nv = src_valid_w[i];
      else                nv = valid_w[i];
      count_d = count_d + CW'(nv);
    end
  end

  // Registered occupancy count, cleared with the stages.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.in_ready = free_c[0] & ~bus.flush;
  assign bus.q        = data_w[DEPTH-1];
  assign bus.q_valid  = valid_w[DEPTH-1];
  assign bus.count    = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: three configurations share one clock and reset
// and are checked by directed scenarios plus randomized traffic against a
// slot-occupancy reference model.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) bus_a ();
  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(3)) bus_b ();
  pipe_reg_chain_if #(.WIDTH(32), .DEPTH(1)) bus_c ();

  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0), .COLLAPSE(1'b0))
    u_a (.Clk(clk), .Clrn(rst_n), .bus(bus_a));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF), .COLLAPSE(1'b1))
    u_b (.Clk(clk), .Clrn(rst_n), .bus(bus_b));
  pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h0), .COLLAPSE(1'b1))
    u_c (.Clk(clk), .Clrn(rst_n), .bus(bus_c));

  int total = 0;
  int bad   = 0;

  // Reference model: per configuration, a list of slots (0 = input side).
  int          dep [3] = '{3, 3, 1};
  bit          col [3] = '{1'b0, 1'b1, 1'b1};
  logic [31:0] rvs [3] = '{32'h0, 32'hDEAD_BEEF, 32'h0};
  bit          mv  [3][16];
  logic [31:0] mp  [3][16];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) begin
        mv[k][i] = 1'b0;
        mp[k][i] = rvs[k];
      end
  endfunction

  // A slot can take new content if the output retires, or in collapse mode
  // if there is any hole at or below it toward the output.
  function automatic bit model_free(int k, int i, logic e);
    if (e) return 1'b1;
    if (!col[k]) return 1'b0;
    for (int j = i; j < dep[k]; j++) if (!mv[k][j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_count(int k);
    int n = 0;
    for (int i = 0; i < dep[k]; i++) n += int'(mv[k][i]);
    return n;
  endfunction

  function automatic void model_step(int k, logic [31:0] d, logic dv, logic e, logic fl);
    bit fr [16];
    for (int i = 0; i < dep[k]; i++) fr[i] = model_free(k, i, e);
    for (int i = dep[k] - 1; i >= 0; i--) begin
      bit          sv;
      logic [31:0] sp;
      sv = (i == 0) ? bit'(dv) : mv[k][i-1];
      sp = (i == 0) ? d : mp[k][i-1];
      if (fl) begin
        mv[k][i] = 1'b0;
        mp[k][i] = rvs[k];
      end else if (fr[i]) begin
        mv[k][i] = sv;
        mp[k][i] = sv ? sp : rvs[k];
      end
    end
  endfunction

  task automatic drive(int k, logic [31:0] d, logic dv, logic e, logic fl);
    case (k)
      0: begin bus_a.D = d; bus_a.d_valid = dv; bus_a.e = e; bus_a.flush = fl; end
      1: begin bus_b.D = d; bus_b.d_valid = dv; bus_b.e = e; bus_b.flush = fl; end
      default: begin bus_c.D = d; bus_c.d_valid = dv; bus_c.e = e; bus_c.flush = fl; end
    endcase
  endtask

  task automatic get_in(int k, output logic [31:0] d, output logic dv, output logic e, output logic fl);
    case (k)
      0: begin d = bus_a.D; dv = bus_a.d_valid; e = bus_a.e; fl = bus_a.flush; end
      1: begin d = bus_b.D; dv = bus_b.d_valid; e = bus_b.e; fl = bus_b.flush; end
      default: begin d = bus_c.D; dv = bus_c.d_valid; e = bus_c.e; fl = bus_c.flush; end
    endcase
  endtask

  task automatic get_out(int k, output logic [31:0] q, output logic qv, output int cnt, output logic rdy);
    case (k)
      0: begin q = bus_a.q; qv = bus_a.q_valid; cnt = int'(bus_a.count); rdy = bus_a.in_ready; end
      1: begin q = bus_b.q; qv = bus_b.q_valid; cnt = int'(bus_b.count); rdy = bus_b.in_ready; end
      default: begin q = bus_c.q; qv = bus_c.q_valid; cnt = int'(bus_c.count); rdy = bus_c.in_ready; end
    endcase
  endtask

  task automatic set_idle();
    for (int k = 0; k < 3; k++) drive(k, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock edge; the model consumes the inputs present at the edge.
  // Returns at the following falling edge.
  task automatic tick();
    logic [31:0] d;
    logic        dv, e, fl;
    @(posedge clk);
    if (!rst_n) model_reset();
    else
      for (int k = 0; k < 3; k++) begin
        get_in(k, d, dv, e, fl);
        model_step(k, d, dv, e, fl);
      end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    logic        qv, rdy;
    int          cnt;
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      get_out(k, q, qv, cnt, rdy);
      total++; if (q !== rvs[k]) begin bad++; $display("FAIL reset_q[%0d]: got %h expected %h", k, q, rvs[k]); end
      total++; if (qv !== 1'b0) begin bad++; $display("FAIL reset_qv[%0d]: got %b expected 0", k, qv); end
      total++; if (cnt != 0) begin bad++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, cnt); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked for all configurations");
  endtask

  task automatic test_reset_midstream();
    set_idle();
    for (int n = 0; n < 3; n++) begin
      drive(0, 32'hC0DE_0000 + 32'(n), 1'b1, 1'b1, 1'b0);
      tick();
    end
    total++; if (bus_a.count !== 2'd3) begin bad++; $display("FAIL mid_fill_count: got %0d expected 3", bus_a.count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus_a.q !== 32'h0) begin bad++; $display("FAIL mid_reset_q: got %h expected 00000000", bus_a.q); end
    total++; if (bus_a.q_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_qv: got %b expected 0", bus_a.q_valid); end
    total++; if (bus_a.count !== 2'd0) begin bad++; $display("FAIL mid_reset_count: got %0d expected 0", bus_a.count); end
    model_reset();
    #1 rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    $display("reset_midstream: async clear checked");
  endtask

  task automatic test_latency();
    logic [31:0] exp_q [6] = '{32'h0, 32'h0, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    logic        exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int          exp_c [6] = '{1, 2, 3, 3, 2, 1};
    for (int n = 1; n <= 6; n++) begin
      if (n <= 4) drive(0, 32'hA5A5_0000 + 32'(n), 1'b1, 1'b1, 1'b0);
      else        drive(0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      total++; if (bus_a.q !== exp_q[n-1]) begin bad++; $display("FAIL latency_q edge %0d: got %h expected %h", n, bus_a.q, exp_q[n-1]); end
      total++; if (bus_a.q_valid !== exp_v[n-1]) begin bad++; $display("FAIL latency_qv edge %0d: got %b expected %b", n, bus_a.q_valid, exp_v[n-1]); end
      total++; if (int'(bus_a.count) != exp_c[n-1]) begin bad++; $display("FAIL latency_count edge %0d: got %0d expected %0d", n, bus_a.count, exp_c[n-1]); end
      $display("latency: edge %0d q=%h qv=%b count=%0d", n, bus_a.q, bus_a.q_valid, bus_a.count);
    end
  endtask

  // Load {0x11, bubble, 0x33} (stage 0 .. stage 2) into configuration k.
  task automatic load_pattern(int k);
    drive(k, 32'h0, 1'b0, 1'b1, 1'b1); tick();
    drive(k, 32'h33, 1'b1, 1'b1, 1'b0); tick();
    drive(k, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    drive(k, 32'h11, 1'b1, 1'b1, 1'b0); tick();
  endtask

  task automatic test_rigid_stall();
    set_idle();
    load_pattern(0);
    for (int n = 0; n < 4; n++) begin
      drive(0, 32'h55, 1'b1, 1'b0, 1'b0);
      #1;
      total++; if (bus_a.in_ready !== 1'b0) begin bad++; $display("FAIL rigid_ready cyc %0d: got %b expected 0", n, bus_a.in_ready); end
      total++; if (bus_a.count !== 2'd2) begin bad++; $display("FAIL rigid_count cyc %0d: got %0d expected 2", n, bus_a.count); end
      total++; if (bus_a.q !== 32'h33 || bus_a.q_valid !== 1'b1) begin bad++; $display("FAIL rigid_q cyc %0d: got %h/%b expected 00000033/1", n, bus_a.q, bus_a.q_valid); end
      tick();
      $display("rigid_stall: cycle %0d q=%h count=%0d", n, bus_a.q, bus_a.count);
    end
    drive(0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    drive(0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    total++; if (bus_a.q !== 32'h11) begin bad++; $display("FAIL rigid_resume_q: got %h expected 00000011", bus_a.q); end
    set_idle();
  endtask

  task automatic test_collapse();
    set_idle();
    load_pattern(1);
    drive(1, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    total++; if (bus_b.count !== 2'd2 || bus_b.q !== 32'h33) begin bad++; $display("FAIL collapse_step1: got count %0d q %h expected 2/00000033", bus_b.count, bus_b.q); end
    drive(1, 32'h44, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus_b.in_ready !== 1'b1) begin bad++; $display("FAIL collapse_ready_hole: got %b expected 1", bus_b.in_ready); end
    tick();
    total++; if (bus_b.count !== 2'd3) begin bad++; $display("FAIL collapse_full_count: got %0d expected 3", bus_b.count); end
    drive(1, 32'h66, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus_b.in_ready !== 1'b0) begin bad++; $display("FAIL collapse_ready_full: got %b expected 0", bus_b.in_ready); end
    tick();
    total++; if (bus_b.count !== 2'd3 || bus_b.q !== 32'h33) begin bad++; $display("FAIL collapse_hold: got count %0d q %h expected 3/00000033", bus_b.count, bus_b.q); end
    drive(1, 32'h66, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (bus_b.in_ready !== 1'b1) begin bad++; $display("FAIL full_advance_ready: got %b expected 1", bus_b.in_ready); end
    tick();
    total++; if (bus_b.count !== 2'd3 || bus_b.q !== 32'h11) begin bad++; $display("FAIL full_advance: got count %0d q %h expected 3/00000011", bus_b.count, bus_b.q); end
    $display("collapse: final q=%h count=%0d", bus_b.q, bus_b.count);
  endtask

  task automatic test_flush();
    drive(1, 32'hFF, 1'b1, 1'b1, 1'b1);
    #1;
    total++; if (bus_b.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b expected 0", bus_b.in_ready); end
    tick();
    total++; if (bus_b.q_valid !== 1'b0 || bus_b.q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL flush_q: got %h/%b expected deadbeef/0", bus_b.q, bus_b.q_valid); end
    total++; if (bus_b.count !== 2'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", bus_b.count); end
    for (int n = 0; n < 4; n++) begin
      drive(1, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
      total++; if (bus_b.q === 32'hFF || bus_b.q_valid !== 1'b0) begin bad++; $display("FAIL flush_leak cyc %0d: got %h/%b expected deadbeef/0", n, bus_b.q, bus_b.q_valid); end
    end
    $display("flush: chain emptied, discarded word never surfaced");
    set_idle();
  endtask

  task automatic test_depth1();
    drive(2, 32'h0, 1'b0, 1'b1, 1'b1); tick();
    drive(2, 32'h7, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus_c.in_ready !== 1'b1) begin bad++; $display("FAIL d1_ready_empty: got %b expected 1", bus_c.in_ready); end
    tick();
    total++; if (bus_c.q !== 32'h7 || bus_c.q_valid !== 1'b1 || bus_c.count !== 1'b1) begin bad++; $display("FAIL d1_accept: got %h/%b/%0d expected 00000007/1/1", bus_c.q, bus_c.q_valid, bus_c.count); end
    drive(2, 32'h8, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus_c.in_ready !== 1'b0) begin bad++; $display("FAIL d1_ready_full: got %b expected 0", bus_c.in_ready); end
    tick();
    total++; if (bus_c.q !== 32'h7) begin bad++; $display("FAIL d1_hold: got %h expected 00000007", bus_c.q); end
    drive(2, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    total++; if (bus_c.in_ready !== 1'b1) begin bad++; $display("FAIL d1_ready_advance: got %b expected 1", bus_c.in_ready); end
    tick();
    total++; if (bus_c.q_valid !== 1'b0 || bus_c.q !== 32'h0 || bus_c.count !== 1'b0) begin bad++; $display("FAIL d1_drain: got %h/%b/%0d expected 00000000/0/0", bus_c.q, bus_c.q_valid, bus_c.count); end
    $display("depth1: accept under stall and drain checked");
    set_idle();
  endtask

  task automatic test_random();
    logic [31:0] q;
    logic        qv, rdy, e, fl;
    int          cnt;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        e  = ($urandom_range(0, 2) != 0);
        fl = ($urandom_range(0, 24) == 0);
        drive(k, $urandom, 1'($urandom_range(0, 1)), e, fl);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        get_in(k, q, qv, e, fl);
        get_out(k, q, qv, cnt, rdy);
        total++; if (q !== mp[k][dep[k]-1]) begin bad++; $display("FAIL rand_q[%0d] cyc %0d: got %h expected %h", k, n, q, mp[k][dep[k]-1]); end
        total++; if (qv !== logic'(mv[k][dep[k]-1])) begin bad++; $display("FAIL rand_qv[%0d] cyc %0d: got %b expected %b", k, n, qv, mv[k][dep[k]-1]); end
        total++; if (cnt != model_count(k)) begin bad++; $display("FAIL rand_count[%0d] cyc %0d: got %0d expected %0d", k, n, cnt, model_count(k)); end
        total++; if (rdy !== logic'(model_free(k, 0, e) & !fl)) begin bad++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", k, n, rdy, model_free(k, 0, e) & !fl); end
      end
      if (n % 50 == 0) $display("random: cycle %0d counts %0d/%0d/%0d", n, model_count(0), model_count(1), model_count(2));
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_reset_midstream();
    test_latency();
    test_rigid_stall();
    test_collapse();
    test_flush();
    test_depth1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
